// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pkg
//  Description : Shared constants for the MIPS decode stage: bus widths,
//                ALU operation bit indices and opcode/funct encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_stage_pkg;

    localparam int FS_BUS_W = 64;
    localparam int DS_BUS_W = 147;
    localparam int BR_BUS_W = 33;

    localparam int ALU_OP_W    = 12;
    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_SLT  = 2;
    localparam int ALU_OP_SLTU = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_NOR  = 5;
    localparam int ALU_OP_OR   = 6;
    localparam int ALU_OP_XOR  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRL  = 9;
    localparam int ALU_OP_SRA  = 10;
    localparam int ALU_OP_LUI  = 11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

endpackage
`default_nettype wire

// File: rtl/id_stage_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 32x32 register file, two asynchronous read ports, one
//                synchronous write port; $0 reads as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile (
    input  logic        clk,
    input  logic [4:0]  i_raddr1,
    output logic [31:0] o_rdata1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_mem [32];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : MIPS decode stage: decodes, reads operands, stalls on RAW
//                hazards, resolves branches and presents the execute bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import id_stage_pkg::*;
#(
    parameter int FS_TO_DS_BUS_WD = FS_BUS_W,
    parameter int DS_TO_ES_BUS_WD = DS_BUS_W,
    parameter int BR_BUS_WD       = BR_BUS_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       ds_allowin,
    input  logic                       es_allowin,
    output logic                       ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic [BR_BUS_WD-1:0]       br_bus,
    input  logic [4:0]                 es_dest,
    input  logic [4:0]                 ms_dest,
    input  logic [4:0]                 ws_dest,
    input  logic                       rf_we,
    input  logic [4:0]                 rf_waddr,
    input  logic [31:0]                rf_wdata
);

    logic                       r_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] r_fs_to_ds_bus;

    logic [31:0] w_pc, w_inst;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_sa;
    logic [15:0] w_imm;
    logic [25:0] w_index;
    logic [31:0] w_rs_value, w_rt_value;

    assign {w_pc, w_inst} = r_fs_to_ds_bus;
    assign w_op    = w_inst[31:26];
    assign w_rs    = w_inst[25:21];
    assign w_rt    = w_inst[20:16];
    assign w_rd    = w_inst[15:11];
    assign w_sa    = w_inst[10:6];
    assign w_funct = w_inst[5:0];
    assign w_imm   = w_inst[15:0];
    assign w_index = w_inst[25:0];

    regfile u_regfile (
        .clk      (clk),
        .i_raddr1 (w_rs),
        .o_rdata1 (w_rs_value),
        .i_raddr2 (w_rt),
        .o_rdata2 (w_rt_value),
        .i_we     (rf_we),
        .i_waddr  (rf_waddr),
        .i_wdata  (rf_wdata)
    );

    logic w_special;
    logic w_addu, w_subu, w_slt, w_sltu, w_and, w_or, w_xor, w_nor;
    logic w_sll, w_srl, w_sra, w_jr;
    logic w_addiu, w_lui, w_lw, w_sw, w_beq, w_bne, w_jal;

    assign w_special = (w_op == OP_SPECIAL);
    assign w_addu  = w_special & (w_funct == FN_ADDU);
    assign w_subu  = w_special & (w_funct == FN_SUBU);
    assign w_slt   = w_special & (w_funct == FN_SLT);
    assign w_sltu  = w_special & (w_funct == FN_SLTU);
    assign w_and   = w_special & (w_funct == FN_AND);
    assign w_or    = w_special & (w_funct == FN_OR);
    assign w_xor   = w_special & (w_funct == FN_XOR);
    assign w_nor   = w_special & (w_funct == FN_NOR);
    assign w_sll   = w_special & (w_funct == FN_SLL);
    assign w_srl   = w_special & (w_funct == FN_SRL);
    assign w_sra   = w_special & (w_funct == FN_SRA);
    assign w_jr    = w_special & (w_funct == FN_JR);
    assign w_addiu = (w_op == OP_ADDIU);
    assign w_lui   = (w_op == OP_LUI);
    assign w_lw    = (w_op == OP_LW);
    assign w_sw    = (w_op == OP_SW);
    assign w_beq   = (w_op == OP_BEQ);
    assign w_bne   = (w_op == OP_BNE);
    assign w_jal   = (w_op == OP_JAL);

    logic [ALU_OP_W-1:0] w_alu_op;

    always_comb begin
        w_alu_op = '0;
        w_alu_op[ALU_OP_ADD]  = w_addu | w_addiu | w_lw | w_sw | w_jal;
        w_alu_op[ALU_OP_SUB]  = w_subu;
        w_alu_op[ALU_OP_SLT]  = w_slt;
        w_alu_op[ALU_OP_SLTU] = w_sltu;
        w_alu_op[ALU_OP_AND]  = w_and;
        w_alu_op[ALU_OP_NOR]  = w_nor;
        w_alu_op[ALU_OP_OR]   = w_or;
        w_alu_op[ALU_OP_XOR]  = w_xor;
        w_alu_op[ALU_OP_SLL]  = w_sll;
        w_alu_op[ALU_OP_SRL]  = w_srl;
        w_alu_op[ALU_OP_SRA]  = w_sra;
        w_alu_op[ALU_OP_LUI]  = w_lui;
    end

    logic        w_shift, w_r_alu;
    logic [31:0] w_simm, w_src1, w_src2;
    logic [4:0]  w_dest;

    assign w_shift = w_sll | w_srl | w_sra;
    assign w_r_alu = w_addu | w_subu | w_slt | w_sltu | w_and | w_or | w_xor | w_nor | w_shift;
    assign w_simm  = {{16{w_imm[15]}}, w_imm};

    assign w_src1 = w_shift ? {27'd0, w_sa} :
                    w_jal   ? w_pc          : w_rs_value;
    assign w_src2 = (w_addiu | w_lw | w_sw) ? w_simm          :
                    w_lui                   ? {16'd0, w_imm}  :
                    w_jal                   ? 32'd8           : w_rt_value;
    assign w_dest = w_r_alu                     ? w_rd  :
                    (w_addiu | w_lui | w_lw)    ? w_rt  :
                    w_jal                       ? 5'd31 : 5'd0;

    // Shift amounts come from sa, so shifts never depend on the rs register.
    logic w_use_rs, w_use_rt, w_rs_hit, w_rt_hit, w_ds_ready_go;

    assign w_use_rs = (w_r_alu & ~w_shift) | w_jr | w_addiu | w_lw | w_sw | w_beq | w_bne;
    assign w_use_rt = w_r_alu | w_sw | w_beq | w_bne;
    assign w_rs_hit = (w_rs != 5'd0) & ((w_rs == es_dest) | (w_rs == ms_dest) | (w_rs == ws_dest));
    assign w_rt_hit = (w_rt != 5'd0) & ((w_rt == es_dest) | (w_rt == ms_dest) | (w_rt == ws_dest));
    assign w_ds_ready_go = ~((w_use_rs & w_rs_hit) | (w_use_rt & w_rt_hit));

    assign ds_allowin     = ~r_ds_valid | (w_ds_ready_go & es_allowin);
    assign ds_to_es_valid = r_ds_valid & w_ds_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            r_ds_valid <= fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (fs_to_ds_valid & ds_allowin) begin
            r_fs_to_ds_bus <= fs_to_ds_bus;
        end
    end

    logic        w_br_taken;
    logic [31:0] w_pc_plus4, w_br_target;

    assign w_pc_plus4  = w_pc + 32'd4;
    assign w_br_taken  = ds_to_es_valid &
                         ((w_beq & (w_rs_value == w_rt_value)) |
                          (w_bne & (w_rs_value != w_rt_value)) | w_jal | w_jr);
    assign w_br_target = w_jal ? {w_pc_plus4[31:28], w_index, 2'b00} :
                         w_jr  ? w_rs_value                           :
                                 w_pc_plus4 + {w_simm[29:0], 2'b00};

    // Target is zeroed when not taken so the redirect bus is clean when idle.
    assign br_bus = {w_br_taken, w_br_taken ? w_br_target : 32'd0};

    assign ds_to_es_bus = {w_alu_op, w_lw, w_sw, w_dest, w_src1, w_src2, w_rt_value, w_pc};

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage: instruction-level model
//                compared every cycle plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [146:0] ds_to_es_bus;
    logic [32:0]  br_bus;
    logic [4:0]   es_dest, ms_dest, ws_dest;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .br_bus         (br_bus),
        .es_dest        (es_dest),
        .ms_dest        (ms_dest),
        .ws_dest        (ws_dest),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
    );

    task automatic check(input string name, input logic [146:0] act, input logic [146:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic [11:0] alu;
        logic        ld;
        logic        st;
        logic [4:0]  dest;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] rtv;
        logic        s2_care;
        logic        use_rs;
        logic        use_rt;
        logic        br;
        logic [31:0] tgt;
    } exp_t;

    logic [31:0] m_rf [32];
    logic        m_valid = 1'b0;
    logic        started = 1'b0;
    logic [31:0] m_pc, m_inst;

    function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] inst);
        exp_t        e;
        int          k;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_v, rt_v, sx;
        rs   = inst[25:21];
        rt   = inst[20:16];
        rd   = inst[15:11];
        rs_v = (rs == 5'd0) ? 32'd0 : m_rf[rs];
        rt_v = (rt == 5'd0) ? 32'd0 : m_rf[rt];
        sx   = {{16{inst[15]}}, inst[15:0]};
        e     = '0;
        e.s1  = rs_v;
        e.s2  = rt_v;
        e.rtv = rt_v;
        k     = -1;
        if (inst[31:26] == 6'd0) begin
            case (inst[5:0])
                6'h21: k = 0;
                6'h23: k = 1;
                6'h2a: k = 2;
                6'h2b: k = 3;
                6'h24: k = 4;
                6'h27: k = 5;
                6'h25: k = 6;
                6'h26: k = 7;
                6'h00: k = 8;
                6'h02: k = 9;
                6'h03: k = 10;
                default: k = -1;
            endcase
            if (k >= 0) begin
                e.alu = 12'd1 << k;
                e.dest = rd;
                e.s2_care = 1'b1;
                e.use_rt = 1'b1;
                e.use_rs = (k < 8);
                if (k >= 8) e.s1 = {27'd0, inst[10:6]};
            end else if (inst[5:0] == 6'h08) begin
                e.use_rs = 1'b1;
                e.s2_care = 1'b1;
                e.br = 1'b1;
                e.tgt = rs_v;
            end
        end else begin
            case (inst[31:26])
                6'h09: begin e.alu = 12'h001; e.dest = rt; e.s2 = sx; e.s2_care = 1'b1; e.use_rs = 1'b1; end
                6'h0f: begin e.alu = 12'h800; e.dest = rt; e.s2 = {16'd0, inst[15:0]}; e.s2_care = 1'b1; end
                6'h23: begin e.alu = 12'h001; e.ld = 1'b1; e.dest = rt; e.s2 = sx; e.s2_care = 1'b1; e.use_rs = 1'b1; end
                6'h2b: begin e.alu = 12'h001; e.st = 1'b1; e.s2 = sx; e.s2_care = 1'b1; e.use_rs = 1'b1; e.use_rt = 1'b1; end
                6'h04: begin e.use_rs = 1'b1; e.use_rt = 1'b1; e.br = (rs_v == rt_v); e.tgt = pc + 32'd4 + (sx << 2); end
                6'h05: begin e.use_rs = 1'b1; e.use_rt = 1'b1; e.br = (rs_v != rt_v); e.tgt = pc + 32'd4 + (sx << 2); end
                6'h03: begin
                    e.alu = 12'h001; e.dest = 5'd31; e.s1 = pc; e.s2 = 32'd8; e.s2_care = 1'b1;
                    e.br = 1'b1; e.tgt = {pc[31:28] + ((pc[27:0] > 28'hffffffb) ? 4'd1 : 4'd0), inst[25:0], 2'b00};
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    exp_t         exp_e;
    logic         exp_valid, exp_allowin, exp_haz;
    logic [32:0]  exp_br;
    logic [146:0] exp_bus, exp_mask;

    always_comb begin
        exp_e = model_decode(m_pc, m_inst);
        exp_haz = (exp_e.use_rs && m_inst[25:21] != 5'd0 &&
                   (m_inst[25:21] == es_dest || m_inst[25:21] == ms_dest || m_inst[25:21] == ws_dest)) ||
                  (exp_e.use_rt && m_inst[20:16] != 5'd0 &&
                   (m_inst[20:16] == es_dest || m_inst[20:16] == ms_dest || m_inst[20:16] == ws_dest));
        exp_valid   = m_valid && !exp_haz;
        exp_allowin = !m_valid || (!exp_haz && es_allowin);
        exp_br      = (exp_valid && exp_e.br) ? {1'b1, exp_e.tgt} : 33'd0;
        exp_bus     = {exp_e.alu, exp_e.ld, exp_e.st, exp_e.dest, exp_e.s1, exp_e.s2, exp_e.rtv, m_pc};
        exp_mask    = '1;
        if (!exp_e.s2_care) exp_mask[95:64] = 32'd0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            started <= 1'b1;
        end else if (exp_allowin) begin
            m_valid <= fs_to_ds_valid;
        end
        if (!reset && fs_to_ds_valid && exp_allowin) begin
            m_pc   <= fs_to_ds_bus[63:32];
            m_inst <= fs_to_ds_bus[31:0];
        end
        if (rf_we && rf_waddr != 5'd0) m_rf[rf_waddr] <= rf_wdata;
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            check("cmp_allowin", ds_allowin, exp_allowin);
            check("cmp_valid", ds_to_es_valid, exp_valid);
            check("cmp_br_bus", br_bus, exp_br);
            if (exp_valid && ds_to_es_valid)
                check("cmp_bus", ds_to_es_bus & exp_mask, exp_bus & exp_mask);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, inst};
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b0;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        @(posedge clk); #1;
        rf_we = 1'b0;
    endtask

    logic [31:0]  tbl [12];
    logic [146:0] held;

    initial begin
        reset = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; es_allowin = 1'b1;
        es_dest = '0; ms_dest = '0; ws_dest = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_valid", ds_to_es_valid, 1'b0);
        check("rst_br_bus", br_bus, 33'd0);
        check("rst_allowin", ds_allowin, 1'b1);
        reset = 1'b0;

        for (int i = 1; i < 32; i++) rf_write(5'(i), 32'h1000_0000 + i * 32'h101);
        rf_write(5'd1, 32'd5);
        rf_write(5'd2, 32'd7);
        rf_write(5'd0, 32'hdead_beef);

        send(32'h0, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        check("addu_valid", ds_to_es_valid, 1'b1);
        check("addu_alu", ds_to_es_bus[146:135], 12'h001);
        check("addu_src1", ds_to_es_bus[127:96], 32'd5);
        check("addu_src2", ds_to_es_bus[95:64], 32'd7);
        check("addu_dest", ds_to_es_bus[132:128], 5'd3);

        send(32'h4, enc_r(5'd0, 5'd2, 5'd4, 5'd3, 6'h00));
        check("sll_alu", ds_to_es_bus[146:135], 12'h100);
        check("sll_src1", ds_to_es_bus[127:96], 32'd3);
        check("sll_src2", ds_to_es_bus[95:64], 32'd7);

        send(32'h8, enc_i(6'h0f, 5'd0, 5'd5, 16'h1234));
        check("lui_alu", ds_to_es_bus[146:135], 12'h800);
        check("lui_src2", ds_to_es_bus[95:64], 32'h0000_1234);
        check("lui_dest", ds_to_es_bus[132:128], 5'd5);

        send(32'h100, enc_i(6'h04, 5'd1, 5'd1, 16'hffff));
        check("beq_br_bus", br_bus, {1'b1, 32'h0000_0100});

        send(32'h104, enc_i(6'h05, 5'd1, 5'd1, 16'h0004));
        check("bne_taken", br_bus[32], 1'b0);

        send(32'h108, 32'hffff_ffff);
        check("unk_alu", ds_to_es_bus[146:135], 12'h000);
        check("unk_dest", ds_to_es_bus[132:128], 5'd0);
        check("unk_mem_we", ds_to_es_bus[133], 1'b0);
        check("unk_br", br_bus[32], 1'b0);

        send(32'h0, {6'h03, 26'h40});
        check("jal_dest", ds_to_es_bus[132:128], 5'd31);
        check("jal_src1", ds_to_es_bus[127:96], 32'd0);
        check("jal_src2", ds_to_es_bus[95:64], 32'd8);
        check("jal_br_bus", br_bus, {1'b1, 32'h0000_0100});

        tbl[0]  = enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h23);
        tbl[1]  = enc_r(5'd7, 5'd1, 5'd9, 5'd0, 6'h2a);
        tbl[2]  = enc_r(5'd7, 5'd1, 5'd9, 5'd0, 6'h2b);
        tbl[3]  = enc_r(5'd6, 5'd7, 5'd9, 5'd0, 6'h24);
        tbl[4]  = enc_r(5'd6, 5'd7, 5'd9, 5'd0, 6'h25);
        tbl[5]  = enc_r(5'd6, 5'd7, 5'd9, 5'd0, 6'h26);
        tbl[6]  = enc_r(5'd6, 5'd7, 5'd9, 5'd0, 6'h27);
        tbl[7]  = enc_r(5'd0, 5'd8, 5'd9, 5'd31, 6'h02);
        tbl[8]  = enc_r(5'd0, 5'd8, 5'd9, 5'd4, 6'h03);
        tbl[9]  = enc_i(6'h09, 5'd2, 5'd10, 16'hfff0);
        tbl[10] = enc_i(6'h23, 5'd2, 5'd8, 16'hfffc);
        tbl[11] = enc_i(6'h2b, 5'd1, 5'd2, 16'h0008);
        for (int i = 0; i < 12; i++) send(32'h500 + 32'(i) * 32'd4, tbl[i]);
        send(32'h540, enc_r(5'd2, 5'd0, 5'd0, 5'd0, 6'h08));
        check("jr_br_bus", br_bus, {1'b1, 32'd7});
        @(posedge clk); #1;

        es_dest = 5'd3;
        send(32'h200, enc_r(5'd3, 5'd0, 5'd6, 5'd0, 6'h21));
        check("haz_valid", ds_to_es_valid, 1'b0);
        check("haz_allowin", ds_allowin, 1'b0);
        @(posedge clk); #1;
        check("haz_hold_valid", ds_to_es_valid, 1'b0);
        es_dest = 5'd0;
        #1;
        check("haz_clear_valid", ds_to_es_valid, 1'b1);
        check("haz_src1", ds_to_es_bus[127:96], 32'h1000_0303);
        check("haz_src2_r0", ds_to_es_bus[95:64], 32'd0);
        @(posedge clk); #1;

        ms_dest = 5'd2;
        send(32'h300, enc_i(6'h04, 5'd2, 5'd2, 16'h0004));
        check("haz_br_hold", br_bus, 33'd0);
        ms_dest = 5'd0;
        #1;
        check("haz_br_release", br_bus, {1'b1, 32'h0000_0314});
        @(posedge clk); #1;

        ws_dest = 5'd1;
        send(32'h380, enc_r(5'd1, 5'd0, 5'd0, 5'd0, 6'h08));
        check("ws_haz_valid", ds_to_es_valid, 1'b0);
        ws_dest = 5'd0;
        #1;
        check("ws_haz_br", br_bus, {1'b1, 32'd5});
        @(posedge clk); #1;

        es_allowin = 1'b0;
        send(32'h400, enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h21));
        held = ds_to_es_bus;
        check("bp_dest", held[132:128], 5'd7);
        check("bp_src1", held[127:96], 32'd5);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h404, enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h25)};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_bus_stable", ds_to_es_bus, held);
            check("bp_valid", ds_to_es_valid, 1'b1);
            check("bp_allowin", ds_allowin, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("bp_rst_valid", ds_to_es_valid, 1'b0);
        check("bp_rst_allowin", ds_allowin, 1'b1);
        reset = 1'b0;
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b1;
        repeat (3) @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
